cic_decim_core: RTL and testbench
=================================

# cic_decim_core

Parametrised N-stage Hogenauer CIC decimator: integrators at the input sample rate, a runtime-selectable decimation ratio, and differential-delay combs at the output rate. It replaces the fixed integrator/decimator/comb trio in the bit-stream filter chain. It takes the ±1 quantised bit-stream samples (or any signed word) and feeds the ISOP compensator and the half-band stage downstream.

## Interface
- `N_STAGES`, default 5: integrator/comb stage count, 1..8.
- `R_MAX`, default 64: largest decimation ratio, at least 2.
- `DIFF_DELAY`, default 1: comb differential delay M, 1 or 2.
- `IN_W`, default 2: signed input width.
- `OUT_W`, default 32: signed output width, at most ACC_W.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: sample enable; `in_data` is accepted on each cycle it is high.
- `in_data`  in  IN_W: signed input sample.
- `dec_ratio`  in  clog2(R_MAX+1): requested decimation ratio R.
- `dout`  out  OUT_W: signed decimated output; holds its value between strobes.
- `rdy`  out  1: one-cycle strobe, `dout` is new.

## Operation
- Width: ACC_W = IN_W + N_STAGES*clog2(R_MAX*DIFF_DELAY). Defaults give 32.
- All integrator and comb arithmetic is two's complement, modulo 2^ACC_W. Wrap-around is intended and is never saturated.
- `in_data` is sign-extended to ACC_W.
- Integrators are pipelined and update only when `in_valid` is high:
  - I1 <= I1 + x
  - Ik <= Ik + I(k-1), using the pre-update value of I(k-1)
- Decimation counter:
  - Counts accepted samples from 0 to R_act-1, then wraps to 0.
  - On the accepted sample with count == R_act-1, `dec_stb` is set for the next cycle.
- Ratio latch:
  - R_act loads from `dec_ratio` on reset and on every counter wrap only. Changes in mid-period are ignored until the wrap.
  - Values below 2 clamp to 2. Values above R_MAX clamp to R_MAX.
- Comb stage, on `dec_stb`:
  - Input is C0 = I_N.
  - Each stage computes Ck = C(k-1) - C(k-1) delayed by DIFF_DELAY strobes.
  - The chain is combinational through all N stages. The delay lines shift only on `dec_stb`.
- Output scaling: `dout` = C_N >>> (ACC_W-OUT_W), an arithmetic shift. It is registered on the cycle after `dec_stb`, with `rdy` pulsing in the same cycle.
- DC gain is (R_act*DIFF_DELAY)^N_STAGES / 2^(ACC_W-OUT_W).
- Startup transient: the first N_STAGES*DIFF_DELAY outputs after reset or a ratio change are transient. Steady state is valid from output N_STAGES*DIFF_DELAY+1.

## Timing
- Reset clears all integrators, comb delay lines, the counter, `dec_stb`, `dout` (0) and `rdy` (0). R_act loads the clamped `dec_ratio`.
- Reset in mid-operation discards the partial period. The next period starts at count 0.
- Latency: the in_valid cycle that completes a period is t. `dec_stb` is high at t+1. `rdy` and `dout` update at t+2.
- `in_valid` may be high on every cycle. `rdy` is therefore never high on back-to-back cycles, since R_act ≥ 2.
- `in_valid` low freezes the integrators and the counter. A pending `dec_stb` or `rdy` still completes.
- No back-pressure: the consumer must take `dout` on `rdy`.

## Configuration
- `CIC_ROUND_EN`:
  - Defined: round half up. Adds 2^(ACC_W-OUT_W-1) to C_N before the shift. The add is modulo, with no extra stage and identical latency.
  - Undefined: plain truncation, which floors toward minus infinity.
  - Both are identical when OUT_W == ACC_W.

## Structure
- Package `cic_pkg`:
  - `clog2` function
  - ACC_W computation function
  - `acc_t` signed typedef helper
  - shift constant (ACC_W-OUT_W)
- Sub-module `cic_comb_stage`:
  - One subtractor plus a DIFF_DELAY-deep delay line, advanced by a strobe input.
  - Instantiated N_STAGES times by generate. The integrators are inline.

## Test plan
- Defaults, `dec_ratio`=64, constant `in_data`=+1 on every cycle: `rdy` every 64 cycles, and `dout` = 1073741824 (2^30) from the 6th `rdy` onward.
- Same setup with `in_data`=-1: `dout` = -1073741824 steady state. Integrator wrap-around produces no error.
- Alternating +1/-1 with R=64: steady-state `dout` = 0.
- Switch `dec_ratio` from 64 to 32 in mid-period: the old period completes at 64 samples. The following periods are 32 samples, with steady `dout` = 33554432 (2^25).
- OUT_W=16, R=33, `in_data`=-1: steady `dout` = -597 with `CIC_ROUND_EN`, -598 without.
- Assert `rst` for one cycle in mid-period with `in_valid` held high: `dout`=0 and `rdy`=0 the cycle after. The next `rdy` comes R+1 cycles after `rst` falls.

Source files
------------

// File: rtl/cic_pkg.sv
// cic_pkg: shared sizing helpers for the CIC decimator.
//   clog2        - ceiling log2 usable in constant expressions
//   acc_width    - integrator/comb word width for a given configuration
//   out_shift    - right shift taking the accumulator word down to the output width
//   acc_t        - signed accumulator word for the default configuration
package cic_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        for (r = 0; (32'd1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Bit growth of an N-stage CIC is N*log2(R*M) on top of the input width.
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned n_stages,
                                              input int unsigned r_max,
                                              input int unsigned diff_delay);
        return in_w + n_stages * clog2(r_max * diff_delay);
    endfunction

    function automatic int unsigned out_shift(input int unsigned acc_w,
                                              input int unsigned out_w);
        return acc_w - out_w;
    endfunction

    localparam int unsigned DefAccW = acc_width(2, 5, 64, 1);

    typedef logic signed [DefAccW-1:0] acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one differentiator of the CIC comb section.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset, clears the delay line
//   stb_i   - output-rate strobe; the delay line advances only on it
//   din_i   - stage input C(k-1)
//   dout_o  - din_i minus din_i as seen DIFF_DELAY strobes ago (combinational)
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stb_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] dout_o
);

    logic signed [W-1:0] dly_q [DIFF_DELAY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DIFF_DELAY; i++) dly_q[i] <= '0;
        end else if (stb_i) begin
            dly_q[0] <= din_i;
            for (int i = 1; i < DIFF_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    // Modulo subtraction; wrap-around in the integrators cancels here.
    assign dout_o = din_i - dly_q[DIFF_DELAY-1];

endmodule

// File: rtl/cic_decim_core.sv
// cic_decim_core: N-stage Hogenauer CIC decimator with runtime decimation ratio.
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - input sample enable
//   in_data    - signed input sample (IN_W bits)
//   dec_ratio  - requested ratio, clamped to [2, R_MAX], taken at reset and at period wrap
//   dout       - signed decimated output, held between strobes
//   rdy        - one-cycle strobe marking a new dout
// Build option: define CIC_ROUND_EN for round-half-up output scaling instead of truncation.
module cic_decim_core
    import cic_pkg::*;
#(
    parameter int unsigned  N_STAGES   = 5,
    parameter int unsigned  R_MAX      = 64,
    parameter int unsigned  DIFF_DELAY = 1,
    parameter int unsigned  IN_W       = 2,
    parameter int unsigned  OUT_W      = 32,
    localparam int unsigned RatioW     = clog2(R_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic [RatioW-1:0]       dec_ratio,
    output logic signed [OUT_W-1:0] dout,
    output logic                    rdy
);

    localparam int unsigned AccW   = acc_width(IN_W, N_STAGES, R_MAX, DIFF_DELAY);
    localparam int unsigned Shift  = out_shift(AccW, OUT_W);
    localparam int unsigned ShiftM1 = (Shift > 0) ? Shift - 1 : 0;

    typedef logic signed [AccW-1:0] word_t;

    localparam word_t RoundAdd = (Shift > 0) ? (word_t'(1) << ShiftM1) : word_t'(0);

    word_t                    integ_q [N_STAGES];
    word_t                    integ_d [N_STAGES];
    logic [RatioW-1:0]        cnt_q;
    logic [RatioW-1:0]        r_act_q;
    logic [RatioW-1:0]        r_req;
    logic                     last_smp;
    logic                     stb_q;
    logic signed [OUT_W-1:0]  dout_q;
    logic signed [OUT_W-1:0]  dout_d;
    logic                     rdy_q;
    word_t                    c_n;
    word_t                    c_n_adj;

    // Pipelined integrators: each stage adds the pre-update value of the one before.
    always_comb begin
        for (int k = 0; k < N_STAGES; k++) integ_d[k] = integ_q[k];
        if (in_valid) begin
            integ_d[0] = integ_q[0] + word_t'(in_data);
            for (int k = 1; k < N_STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    always_comb begin
        if (dec_ratio < RatioW'(2)) begin
            r_req = RatioW'(2);
        end else if (dec_ratio > RatioW'(R_MAX)) begin
            r_req = RatioW'(R_MAX);
        end else begin
            r_req = dec_ratio;
        end
    end

    assign last_smp = (cnt_q == r_act_q - 1'b1);

    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        word_t c_in;
        word_t c_out;
        if (k == 0) begin : g_first
            assign c_in = integ_q[N_STAGES-1];
        end else begin : g_next
            assign c_in = g_comb[k-1].c_out;
        end
        cic_comb_stage #(
            .W          (AccW),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk_i  (clk),
            .rst_i  (rst),
            .stb_i  (stb_q),
            .din_i  (c_in),
            .dout_o (c_out)
        );
    end

    assign c_n = g_comb[N_STAGES-1].c_out;

    always_comb begin
        c_n_adj = c_n;
`ifdef CIC_ROUND_EN
        c_n_adj = c_n + RoundAdd;
`endif
        dout_d = OUT_W'(c_n_adj >>> Shift);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_STAGES; k++) integ_q[k] <= '0;
            cnt_q   <= '0;
            r_act_q <= r_req;
            stb_q   <= 1'b0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            integ_q <= integ_d;
            if (in_valid) begin
                if (last_smp) begin
                    cnt_q   <= '0;
                    r_act_q <= r_req;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            stb_q <= in_valid & last_smp;
            rdy_q <= stb_q;
            if (stb_q) dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
    assign rdy  = rdy_q;

endmodule

// File: tb/tb_cic_decim_core.sv
// Directed bench for cic_decim_core: a scoreboard queue of expected outputs and rdy
// spacings is filled per phase and drained as rdy strobes appear. A second instance
// with OUT_W=16 checks output scaling (truncate vs. CIC_ROUND_EN rounding).
module tb_cic_decim_core;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [1:0]  in_data;
    logic [6:0]         dec_ratio;
    logic [6:0]         dec16;
    logic signed [31:0] dout;
    logic               rdy;
    logic signed [15:0] dout16;
    logic               rdy16;

    always #5 clk = ~clk;

    cic_decim_core u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .dec_ratio (dec_ratio),
        .dout      (dout),
        .rdy       (rdy)
    );

    cic_decim_core #(
        .OUT_W (16)
    ) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .dec_ratio (dec16),
        .dout      (dout16),
        .rdy       (rdy16)
    );

    typedef struct {
        bit     chk;
        longint val;
        int     gap;
        string  tag;
    } exp_t;

    exp_t              sb [$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                last_evt = 0;
    int                samp     = 0;
    int                n_rdy16  = 0;
    int                mode     = 0;
    logic signed [1:0] const_val;
    bit                sparse   = 1'b0;
    bit                chk16    = 1'b0;
    longint            exp16;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit chk, input longint val, input int gap);
        exp_t e;
        e.tag = tag;
        e.chk = chk;
        e.val = val;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Standard period pattern: first output comes R+1 cycles after reset, the rest every R.
    task automatic push_periods(input string tag, input int n, input int r,
                                input int first_chk, input longint val);
        for (int k = 1; k <= n; k++) begin
            push(tag, k >= first_chk, val, (k == 1) ? r + 1 : r);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_rdy", rdy, 0);
        end else begin
            e = sb.pop_front();
            if (e.gap != 0) check({e.tag, "_gap"}, cyc - last_evt, e.gap);
            if (e.chk) check(e.tag, dout, e.val);
        end
        last_evt = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = sparse ? ((i % 2) == 0) : 1'b1;
            if (mode == 1) in_data = (samp % 2 == 0) ? 2'sb01 : 2'sb11;
            else           in_data = const_val;
            if (in_valid) samp++;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) pop_check();
            if (rdy16) begin
                n_rdy16++;
                if (chk16 && n_rdy16 >= 6) check("r33_out16", dout16, exp16);
            end
        end
    endtask

    // One reset cycle; in_valid and in_data keep whatever they were driven to.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check("rst_dout", dout, 0);
        check("rst_rdy", rdy, 0);
        rst      = 1'b0;
        last_evt = cyc;
        samp     = 0;
        n_rdy16  = 0;
    endtask

    initial begin
`ifdef CIC_ROUND_EN
        exp16 = -597;
`else
        exp16 = -598;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 2'sb00;
        dec_ratio = 7'd64;
        dec16     = 7'd33;
        const_val = 2'sb01;

        // Reset from power-up.
        do_reset();

        // Constant +1, R=64: steady 2^30 from the 6th output.
        mode = 0;
        const_val = 2'sb01;
        push_periods("dc_pos", 8, 64, 6, 64'sd1073741824);
        run(513);
        run(20);
        check("sb_drained_a", sb.size(), 0);

        // Mid-period reset with in_valid high, then constant -1.
        const_val = 2'sb11;
        do_reset();
        chk16 = 1'b1;
        push_periods("dc_neg", 7, 64, 6, -64'sd1073741824);
        run(449);
        chk16 = 1'b0;
        check("r33_count", n_rdy16, 13);
        check("sb_drained_b", sb.size(), 0);

        // Alternating +1/-1 sits on a CIC null.
        mode = 1;
        do_reset();
        push_periods("alt", 8, 64, 6, 0);
        run(513);
        check("sb_drained_c", sb.size(), 0);

        // Ratio change mid-period: first period stays 64, then 32-sample periods.
        mode = 0;
        const_val = 2'sb01;
        dec_ratio = 7'd64;
        do_reset();
        push("r64to32", 1'b0, 0, 65);
        for (int k = 2; k <= 9; k++) push("r64to32", k >= 7, 64'sd33554432, 32);
        run(10);
        dec_ratio = 7'd32;
        run(311);
        check("sb_drained_d", sb.size(), 0);

        // Ratio 0 clamps to 2; in_valid every other cycle freezes state in between.
        sparse = 1'b1;
        dec_ratio = 7'd0;
        do_reset();
        push("clamp2", 1'b0, 0, 4);
        for (int k = 2; k <= 10; k++) push("clamp2", k >= 6, 64'sd32, 4);
        run(42);
        check("sb_drained_e", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
